// File: rtl/agu_nd_multi_pkg.sv
// Shared definitions for the multi-channel address generator.
// Build option: AGU_HASH_EN adds the hash-load path (see agu_channel).
package agu_pkg;
  localparam int AGU_ADDR_WIDTH = 12;
  localparam int AGU_NUM_CH     = 4;
  localparam int AGU_STRIDE_W   = 4;
  localparam int AGU_CNT_W      = 12;
  localparam int AW2            = AGU_ADDR_WIDTH + 2;

  // Low bit index of channel c inside a flat bus of w-bit fields.
  function automatic int ch_lo(input int c, input int w);
    return c * w;
  endfunction
endpackage

// File: rtl/agu_nd_multi_if.sv
// Configuration/strobe/address bundle between control FSM and the address generator.
// Hash signals exist only when AGU_HASH_EN is defined.
interface agu_nd_multi_if
  import agu_pkg::*;
#(
  parameter int ADDR_WIDTH = AGU_ADDR_WIDTH,
  parameter int NUM_CH     = AGU_NUM_CH,
  parameter int STRIDE_W   = AGU_STRIDE_W,
  parameter int CNT_W      = AGU_CNT_W
);
  localparam int FULL_W = ADDR_WIDTH + 2;

  logic [NUM_CH-1:0]          cfg_we;
  logic [NUM_CH*FULL_W-1:0]   cfg_start;
  logic [NUM_CH*STRIDE_W-1:0] cfg_stride;
  logic [NUM_CH*CNT_W-1:0]    cfg_row_len;
  logic [NUM_CH*FULL_W-1:0]   cfg_pitch;
  logic [NUM_CH-1:0]          clr_en;
  logic [NUM_CH-1:0]          add_en;
`ifdef AGU_HASH_EN
  logic [NUM_CH-1:0]          hash_en;
  logic [ADDR_WIDTH-1:0]      hash_addr;
  logic                       hash_inc;
`endif
  logic [NUM_CH*FULL_W-1:0]   addr;
  logic [NUM_CH-1:0]          row_wrap;
  logic [NUM_CH-1:0]          busy;

  modport master (
    output cfg_we, cfg_start, cfg_stride, cfg_row_len, cfg_pitch, clr_en, add_en,
`ifdef AGU_HASH_EN
    output hash_en, hash_addr, hash_inc,
`endif
    input  addr, row_wrap, busy
  );

  modport slave (
    input  cfg_we, cfg_start, cfg_stride, cfg_row_len, cfg_pitch, clr_en, add_en,
`ifdef AGU_HASH_EN
    input  hash_en, hash_addr, hash_inc,
`endif
    output addr, row_wrap, busy
  );
endinterface

// File: rtl/agu_nd_multi_channel.sv
// One address-generator channel: shadow config, 2-D row walk, busy/row_wrap flags.
// With AGU_HASH_EN defined a hash load sits between clear and advance in priority.
module agu_channel
  import agu_pkg::*;
#(
  parameter int ADDR_WIDTH = AGU_ADDR_WIDTH,
  parameter int STRIDE_W   = AGU_STRIDE_W,
  parameter int CNT_W      = AGU_CNT_W,
  localparam int FULL_W    = ADDR_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_we,
  input  logic [FULL_W-1:0]     cfg_start,
  input  logic [STRIDE_W-1:0]   cfg_stride,
  input  logic [CNT_W-1:0]      cfg_row_len,
  input  logic [FULL_W-1:0]     cfg_pitch,
  input  logic                  clr_en,
  input  logic                  add_en,
`ifdef AGU_HASH_EN
  input  logic                  hash_en,
  input  logic [ADDR_WIDTH-1:0] hash_addr,
  input  logic                  hash_inc,
`endif
  output logic [FULL_W-1:0]     addr,
  output logic                  row_wrap,
  output logic                  busy
);
  logic [FULL_W-1:0]   start_q, pitch_q, row_base_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [CNT_W-1:0]    row_len_q, col_cnt_q;
  logic                wrap_seen_q;
  logic [FULL_W-1:0]   clr_start, next_base;
  logic                last_col;

  // 1-D mode column counter stops at all-ones instead of rolling over.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic sat);
    return (sat && (&v)) ? v : v + CNT_W'(1);
  endfunction

  assign clr_start = cfg_we ? cfg_start : start_q;
  assign next_base = row_base_q + pitch_q;
  assign last_col  = (row_len_q != '0) && (col_cnt_q == row_len_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q     <= '0;
      stride_q    <= '0;
      row_len_q   <= '0;
      pitch_q     <= '0;
      addr        <= '0;
      row_base_q  <= '0;
      col_cnt_q   <= '0;
      row_wrap    <= 1'b0;
      busy        <= 1'b0;
      wrap_seen_q <= 1'b0;
    end else begin
      if (cfg_we) begin
        start_q   <= cfg_start;
        stride_q  <= cfg_stride;
        row_len_q <= cfg_row_len;
        pitch_q   <= cfg_pitch;
      end
      row_wrap <= 1'b0;
      if (clr_en) begin
        addr        <= clr_start;
        row_base_q  <= clr_start;
        col_cnt_q   <= '0;
        busy        <= 1'b1;
        wrap_seen_q <= 1'b0;
      end
`ifdef AGU_HASH_EN
      else if (hash_en) begin
        addr <= start_q + FULL_W'(hash_addr) + FULL_W'(hash_inc);
      end
`endif
      else if (add_en) begin
        if (last_col) begin
          col_cnt_q   <= '0;
          row_base_q  <= next_base;
          addr        <= next_base;
          row_wrap    <= 1'b1;
          wrap_seen_q <= 1'b1;
        end else begin
          addr      <= addr + FULL_W'(stride_q);
          col_cnt_q <= sat_inc(col_cnt_q, row_len_q == '0);
        end
      end else if (wrap_seen_q) begin
        // First idle cycle after a wrap releases the channel.
        busy        <= 1'b0;
        wrap_seen_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/agu_nd_multi.sv
// Multi-channel 2-D address generator; slices the flat buses onto NUM_CH agu_channel instances.
// Build option: AGU_HASH_EN enables the per-channel hash load.
module agu_nd_multi
  import agu_pkg::*;
#(
  parameter int ADDR_WIDTH = AGU_ADDR_WIDTH,
  parameter int NUM_CH     = AGU_NUM_CH,
  parameter int STRIDE_W   = AGU_STRIDE_W,
  parameter int CNT_W      = AGU_CNT_W
) (
  input logic           clk,
  input logic           rstn,
  agu_nd_multi_if.slave bus
);
  localparam int FULL_W = ADDR_WIDTH + 2;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    agu_channel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .STRIDE_W   (STRIDE_W),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rstn        (rstn),
      .cfg_we      (bus.cfg_we[c]),
      .cfg_start   (bus.cfg_start[ch_lo(c, FULL_W) +: FULL_W]),
      .cfg_stride  (bus.cfg_stride[ch_lo(c, STRIDE_W) +: STRIDE_W]),
      .cfg_row_len (bus.cfg_row_len[ch_lo(c, CNT_W) +: CNT_W]),
      .cfg_pitch   (bus.cfg_pitch[ch_lo(c, FULL_W) +: FULL_W]),
      .clr_en      (bus.clr_en[c]),
      .add_en      (bus.add_en[c]),
`ifdef AGU_HASH_EN
      .hash_en     (bus.hash_en[c]),
      .hash_addr   (bus.hash_addr),
      .hash_inc    (bus.hash_inc),
`endif
      .addr        (bus.addr[ch_lo(c, FULL_W) +: FULL_W]),
      .row_wrap    (bus.row_wrap[c]),
      .busy        (bus.busy[c])
    );
  end
endmodule

// File: tb/tb_agu_nd_multi.sv
// Directed bench for agu_nd_multi: 1-D walk, 2-D walk with wraps, modulo wrap, bypass, hash, async reset.
module tb_agu_nd_multi;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  agu_nd_multi_if bus ();

  agu_nd_multi dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int c);
    return 32'(bus.addr[c*AW +: AW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int c, input logic [13:0] st, input logic [3:0] sd,
                         input logic [11:0] rl, input logic [13:0] pt);
    bus.cfg_start[c*AW +: AW]   = st;
    bus.cfg_stride[c*4 +: 4]    = sd;
    bus.cfg_row_len[c*12 +: 12] = rl;
    bus.cfg_pitch[c*AW +: AW]   = pt;
  endtask

  task automatic cfg(input int c, input logic [13:0] st, input logic [3:0] sd,
                     input logic [11:0] rl, input logic [13:0] pt);
    set_cfg(c, st, sd, rl, pt);
    bus.cfg_we[c] = 1'b1;
    tick();
    bus.cfg_we = '0;
  endtask

  task automatic strobe(input logic [3:0] clr, input logic [3:0] add);
    bus.clr_en = clr;
    bus.add_en = add;
    tick();
    bus.clr_en = '0;
    bus.add_en = '0;
  endtask

  logic [13:0] t2_addr [7] = '{14'h102, 14'h104, 14'h140, 14'h142, 14'h144, 14'h180, 14'h182};
  logic        t2_wrap [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    bus.cfg_we = '0; bus.cfg_start = '0; bus.cfg_stride = '0;
    bus.cfg_row_len = '0; bus.cfg_pitch = '0; bus.clr_en = '0; bus.add_en = '0;
`ifdef AGU_HASH_EN
    bus.hash_en = '0; bus.hash_addr = '0; bus.hash_inc = 1'b0;
`endif
    #12;
    chk("reset_addr", 32'(bus.addr), 32'h0);
    chk("reset_row_wrap", 32'(bus.row_wrap), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // T1: 1-D walk on channel 0
    cfg(0, 14'h010, 4'd1, 12'd0, 14'h0);
    chk("t1_cfg_no_addr", addr_of(0), 32'h0);
    strobe(4'b0001, 4'b0000);
    chk("t1_clr_addr", addr_of(0), 32'h010);
    chk("t1_clr_busy", 32'(bus.busy[0]), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      strobe(4'b0000, 4'b0001);
      chk($sformatf("t1_addr_%0d", i), addr_of(0), 32'h010 + 32'(i));
      chk($sformatf("t1_wrap_%0d", i), 32'(bus.row_wrap[0]), 32'h0);
    end

    // T2: 2-D walk on channel 1
    cfg(1, 14'h100, 4'd2, 12'd3, 14'h040);
    strobe(4'b0010, 4'b0000);
    chk("t2_clr_addr", addr_of(1), 32'h100);
    for (int i = 0; i < 7; i++) begin
      strobe(4'b0000, 4'b0010);
      chk($sformatf("t2_addr_%0d", i), addr_of(1), 32'(t2_addr[i]));
      chk($sformatf("t2_wrap_%0d", i), 32'(bus.row_wrap[1]), 32'(t2_wrap[i]));
    end
    chk("t2_busy_held", 32'(bus.busy[1]), 32'h1);
    tick();
    chk("t2_busy_drop", 32'(bus.busy[1]), 32'h0);
    chk("t2_idle_addr", addr_of(1), 32'h182);

    // T3: modulo wrap and clear priority on channel 2
    cfg(2, 14'h3FFE, 4'd3, 12'd0, 14'h0);
    strobe(4'b0100, 4'b0000);
    strobe(4'b0000, 4'b0100);
    chk("t3_mod_wrap", addr_of(2), 32'h0001);
    strobe(4'b0100, 4'b0100);
    chk("t3_clr_beats_add", addr_of(2), 32'h3FFE);

    // T4: config bypass on channel 3, then all channels advance together
    set_cfg(3, 14'h222, 4'd5, 12'd0, 14'h0);
    bus.cfg_we[3] = 1'b1;
    strobe(4'b1000, 4'b0000);
    chk("t4_bypass", addr_of(3), 32'h222);
    strobe(4'b0000, 4'b1111);
    chk("t4_all_ch0", addr_of(0), 32'h016);
    chk("t4_all_ch1", addr_of(1), 32'h184);
    chk("t4_all_ch2", addr_of(2), 32'h0001);
    chk("t4_all_ch3", addr_of(3), 32'h227);
    strobe(4'b0000, 4'b1111);
    chk("t4_wrap_only_ch1", 32'(bus.row_wrap), 32'h2);
    chk("t4_ch1_wrap_addr", addr_of(1), 32'h1C0);
    chk("t4_ch0", addr_of(0), 32'h017);
    chk("t4_ch2", addr_of(2), 32'h0004);
    chk("t4_ch3", addr_of(3), 32'h22C);

`ifdef AGU_HASH_EN
    // T5: hash load and its priority over add
    cfg(0, 14'h800, 4'd1, 12'd0, 14'h0);
    bus.hash_addr = 12'h015;
    bus.hash_inc  = 1'b1;
    bus.hash_en   = 4'b0001;
    tick();
    bus.hash_en   = '0;
    chk("t5_hash", addr_of(0), 32'h816);
    bus.hash_en   = 4'b0001;
    strobe(4'b0000, 4'b0001);
    bus.hash_en   = '0;
    chk("t5_hash_beats_add", addr_of(0), 32'h816);
    chk("t5_hash_no_wrap", 32'(bus.row_wrap[0]), 32'h0);
`endif

    // T6: asynchronous reset in the middle of a 2-D walk
    strobe(4'b0010, 4'b0000);
    strobe(4'b0000, 4'b0010);
    strobe(4'b0000, 4'b0010);
    strobe(4'b0000, 4'b0010);
    chk("t6_pre_wrap", 32'(bus.row_wrap[1]), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_addr", 32'(bus.addr), 32'h0);
    chk("t6_async_wrap", 32'(bus.row_wrap), 32'h0);
    chk("t6_async_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    strobe(4'b0000, 4'b0010);
    chk("t6_post_reset_stride0", addr_of(1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
